// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle row pattern,
// key code width and helpers for decoding an active-low column pattern.
package keypad_pkg;

  localparam int CODE_W = 4;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // True when exactly one of the active-low column lines is pulled down.
  function automatic logic one_low(input logic [3:0] col);
    return (col == 4'b1110) || (col == 4'b1101) ||
           (col == 4'b1011) || (col == 4'b0111);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate divider: one-cycle tick_o every SCAN_DIV clocks, counter cleared by reset
// so the first tick lands SCAN_DIV clocks after reset release.
module scan_tick #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces a single
// key press and release, and reports one key_valid pulse per accepted key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_col,
  output logic [3:0]        key_row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_pressed
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DT = CW'(DEBOUNCE_TICKS);

  logic tick;

  state_t            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        cap_col_q, cap_col_d;
  logic [CW-1:0]     match_q, match_d;
  logic [CW-1:0]     rel_q, rel_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     match_inc, rel_inc;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Saturating increments so neither counter can wrap back below the threshold.
  assign match_inc = (match_q == DT) ? match_q : match_q + 1'b1;
  assign rel_inc   = (rel_q == DT)   ? rel_q   : rel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cap_col_d = cap_col_q;
    match_d   = match_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low(key_col)) begin
            cap_col_d = key_col;
            match_d   = CW'(1);
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (key_col == cap_col_q) begin
            match_d = match_inc;
            if (match_inc == DT) begin
              state_d = HOLD;
              code_d  = {row_q, col_index(cap_col_q)};
              valid_d = 1'b1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 1'b1;
          end
        end
        HOLD: begin
          if (key_col == ROW_IDLE) begin
            state_d = RELEASE;
            rel_d   = CW'(1);
          end
        end
        RELEASE: begin
          if (key_col == ROW_IDLE) begin
            rel_d = rel_inc;
            if (rel_inc == DT) begin
              state_d = SCAN;
              row_d   = 2'd0;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      cap_col_q <= ROW_IDLE;
      match_q   <= '0;
      rel_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cap_col_q <= cap_col_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign key_row     = ~(4'b0001 << row_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3 and a
// behavioural keypad that closes one switch between a row and a column.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic       press_en  = 1'b0;
  int         pr        = 0;
  int         pc        = 0;
  logic       force_en  = 1'b0;
  logic [3:0] force_col = 4'hF;

  int n_tests = 0;
  int n_fail  = 0;
  int ec      = 0;
  int valid_cnt = 0;
  int base;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .key_row     (key_row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_col = 4'hF;
    if (force_en) key_col = force_col;
    else if (press_en && key_row[pr] == 1'b0) key_col = ~(4'b0001 << pc);
  end

  always @(negedge clk) if (key_valid) valid_cnt <= valid_cnt + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    ec = ec + n;
  endtask

  task automatic to_edge(input int t);
    step(t - ec);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    ec = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_row", key_row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_pressed", key_pressed, 0);
    chk("rst_code", key_code, 0);

    // Idle scan
    do_reset();
    base = valid_cnt;
    to_edge(3);  chk("idle_pre_tick", key_row, 4'b1110);
    to_edge(4);  chk("idle_r1", key_row, 4'b1101);
    to_edge(8);  chk("idle_r2", key_row, 4'b1011);
    to_edge(12); chk("idle_r3", key_row, 4'b0111);
    to_edge(16); chk("idle_wrap", key_row, 4'b1110);
    to_edge(20); chk("idle_r1b", key_row, 4'b1101);
    chk("idle_novalid", valid_cnt - base, 0);

    // Stable press row 2 / col 1, long hold, second key ignored, release
    do_reset();
    base = valid_cnt;
    press_en = 1'b1; pr = 2; pc = 1;
    to_edge(12); chk("press_detect_row", key_row, 4'b1011);
    chk("press_deb_notpressed", key_pressed, 0);
    to_edge(19); chk("press_prevalid", key_valid, 0);
    to_edge(20);
    chk("press_valid", key_valid, 1);
    chk("press_code", key_code, 4'h9);
    chk("press_pressed", key_pressed, 1);
    to_edge(21); chk("press_valid_pulse", key_valid, 0);
    to_edge(40);
    force_en = 1'b1; force_col = 4'b0111;
    to_edge(60); force_en = 1'b0;
    chk("hold_second_ignored", valid_cnt - base, 1);
    chk("hold_code_kept", key_code, 4'h9);
    chk("hold_pressed", key_pressed, 1);
    to_edge(100);
    press_en = 1'b0;
    to_edge(104); chk("rel_pressed1", key_pressed, 1);
    to_edge(111); chk("rel_pressed_late", key_pressed, 1);
    to_edge(112);
    chk("rel_done_pressed", key_pressed, 0);
    chk("rel_row0", key_row, 4'b1110);
    chk("rel_one_valid", valid_cnt - base, 1);
    chk("rel_code_kept", key_code, 4'h9);
    to_edge(116); chk("rel_scan_resume", key_row, 4'b1101);

    // Bounce: row 1 / col 3 seen once then gone
    do_reset();
    base = valid_cnt;
    press_en = 1'b1; pr = 1; pc = 3;
    to_edge(8); press_en = 1'b0;
    chk("bounce_held_row", key_row, 4'b1101);
    to_edge(12);
    chk("bounce_row2", key_row, 4'b1011);
    chk("bounce_notpressed", key_pressed, 0);
    to_edge(24); chk("bounce_novalid", valid_cnt - base, 0);

    // Two columns low: no debounce
    do_reset();
    base = valid_cnt;
    force_en = 1'b1; force_col = 4'b1100;
    to_edge(4); chk("multi_r1", key_row, 4'b1101);
    to_edge(8); chk("multi_r2", key_row, 4'b1011);
    to_edge(24);
    chk("multi_novalid", valid_cnt - base, 0);
    chk("multi_notpressed", key_pressed, 0);
    force_en = 1'b0;

    // Reset during debounce after 2 matches
    do_reset();
    base = valid_cnt;
    press_en = 1'b1; pr = 2; pc = 1;
    to_edge(17);
    rst = 1'b1;
    to_edge(18);
    chk("abort_row", key_row, 4'b1110);
    chk("abort_valid", key_valid, 0);
    chk("abort_pressed", key_pressed, 0);
    chk("abort_code", key_code, 0);
    to_edge(24);
    chk("abort_novalid", valid_cnt - base, 0);
    rst = 1'b0;
    ec = 0;
    to_edge(3); chk("first_tick_pre", key_row, 4'b1110);
    to_edge(4); chk("first_tick", key_row, 4'b1101);
    press_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
